// File: rtl/ser_pkg.sv
// Shared types and helpers for the PISO serializer.
// FSM state encoding and counter width helper.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // gap counter width (covers 0..15 idle cycles)
  localparam int GAP_W = 4;

  // counter width for n positions, never below 1
  function automatic int CNT_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake and serial stream bundle.
// master: word producer; slave: serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             done;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  done,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output done,
    output busy
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Up-counter with sync clear, enable and terminal count.
// clk/rst, i_load (clear), i_en, o_cnt, o_tc (cnt==MAX).
module ser_bit_counter #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

  // holds at LAST so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with framing strobes.
// clk, rst, bus (slave): word handshake in, serial stream out.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int CW   = CNT_W(WIDTH);
  localparam int GMAX =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;

  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_frame_start;
  logic             r_done;
  logic             r_busy;

  logic             w_ser_out;
  logic             w_ser_valid;
  logic             w_frame_start;
  logic             w_done;
  logic             w_busy;

  logic             w_hs;
  logic             w_in_shift;
  logic             w_in_gap;
  logic             w_gap_ld;
  logic [CW-1:0]    w_bit_cnt;
  logic             w_bit_tc;
  logic [CW-1:0]    w_idx;
  logic             w_bit;
  logic [GAP_W-1:0] w_unused_gap_cnt;
  logic             w_gap_tc;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_in_gap   = (r_state == ST_GAP);
  assign w_hs       = bus.in_valid
                    & (r_state == ST_IDLE);
  assign w_gap_ld   = w_in_shift & w_bit_tc;

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.ser_out     = r_ser_out;
  assign bus.ser_valid   = r_ser_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;

  ser_bit_counter #(
    .W   (CW),
    .MAX (WIDTH - 1)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_hs),
    .i_en   (w_in_shift),
    .o_cnt  (w_bit_cnt),
    .o_tc   (w_bit_tc)
  );

  ser_bit_counter #(
    .W   (GAP_W),
    .MAX (GMAX)
  ) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_gap_ld),
    .i_en   (w_in_gap),
    .o_cnt  (w_unused_gap_cnt),
    .o_tc   (w_gap_tc)
  );

  // bit k of the word, in wire order
  assign w_idx = (LSB_FIRST != 0)
               ? w_bit_cnt
               : CW'(WIDTH - 1) - w_bit_cnt;
  assign w_bit = r_shreg[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_hs) begin
      r_shreg <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_ser_out     <= w_ser_out;
      r_ser_valid   <= w_ser_valid;
      r_frame_start <= w_frame_start;
      r_done        <= w_done;
      r_busy        <= w_busy;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_bit_tc) begin
          w_next = (GAP_CYCLES > 0)
                 ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_gap_tc) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // next values of the registered outputs;
  // busy tracks the state being entered
  always_comb begin
    w_ser_out     = 1'b0;
    w_ser_valid   = 1'b0;
    w_frame_start = 1'b0;
    w_done        = 1'b0;
    w_busy        = (w_next != ST_IDLE);
    if (w_in_shift) begin
      w_ser_out     = w_bit;
      w_ser_valid   = 1'b1;
      w_frame_start = (w_bit_cnt == '0);
      w_done        = w_bit_tc;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configs fed in parallel.
// inst0 MSB/no gap, inst1 gap=2, inst2 LSB first.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] tin_data [3];
  logic [2:0] tin_valid;
  logic [2:0] t_rdy;
  logic [2:0] t_so;
  logic [2:0] t_sv;
  logic [2:0] t_fs;
  logic [2:0] t_dn;
  logic [2:0] t_busy;

  exp_t       sbq [3][$];
  logic [3:0] wq  [3][$];
  logic [3:0] la  [3];
  int         dcnt [3];
  int         vlow [3];
  int         rlow [3];
  bit         seen [3];
  bit         bb;
  int         nvec;
  int         nerr;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    piso_serializer_if #(.WIDTH(4)) bus ();

    piso_serializer #(
      .WIDTH      (4),
      .LSB_FIRST  ((g == 2) ? 1 : 0),
      .GAP_CYCLES ((g == 1) ? 2 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.in_data  = tin_data[g];
    assign bus.in_valid = tin_valid[g];
    assign t_rdy[g]     = bus.in_ready;
    assign t_so[g]      = bus.ser_out;
    assign t_sv[g]      = bus.ser_valid;
    assign t_fs[g]      = bus.frame_start;
    assign t_dn[g]      = bus.done;
    assign t_busy[g]    = bus.busy;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gap_of(input int g);
    return (g == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input int g,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s inst%0d observed %0h expected %0h",
             tag, g, obs, exp);
    end
  endtask

  task automatic push_exp(input int g,
                          input logic [3:0] w);
    exp_t e;
    int   idx;
    for (int k = 0; k < 4; k++) begin
      idx  = (g == 2) ? k : 3 - k;
      e.b  = w[idx];
      e.fs = (k == 0);
      e.dn = (k == 3);
      sbq[g].push_back(e);
    end
  endtask

  task automatic check(input int g);
    exp_t e;
    if (rst) begin
      chk("rst_out", g,
          {t_so[g], t_sv[g], t_fs[g], t_dn[g], t_busy[g]},
          8'h00);
      return;
    end
    chk("busy_vs_rdy", g, t_busy[g], !t_rdy[g]);
    if (t_sv[g]) begin
      if (bb && seen[g] && vlow[g] > 0)
        chk("gap", g, vlow[g], 1 + gap_of(g));
      vlow[g] = 0;
      if (sbq[g].size() == 0) begin
        chk("unexp_bit", g, 8'h01, 8'h00);
      end else begin
        e = sbq[g].pop_front();
        chk("bit", g, {t_so[g], t_fs[g], t_dn[g]}, e);
      end
      la[g] = {la[g][2:0], t_so[g]};
      if (t_dn[g]) begin
        dcnt[g]++;
        seen[g] = 1'b1;
      end
    end else begin
      chk("idle_out", g,
          {t_so[g], t_fs[g], t_dn[g]}, 8'h00);
      vlow[g]++;
    end
    if (t_rdy[g]) begin
      if (rlow[g] > 0)
        chk("rdy_low", g, rlow[g], 4 + gap_of(g));
      rlow[g] = 0;
    end else begin
      rlow[g]++;
    end
  endtask

  // inputs change at negedge; a word is logged
  // when valid&ready will meet at the next edge
  task automatic drive(input int g);
    if (rst) begin
      tin_valid[g] = 1'b0;
      return;
    end
    if (wq[g].size() > 0) begin
      tin_valid[g] = 1'b1;
      tin_data[g]  = wq[g][0];
      if (t_rdy[g]) begin
        push_exp(g, wq[g][0]);
        void'(wq[g].pop_front());
      end
    end else begin
      tin_valid[g] = 1'b0;
      tin_data[g]  = 4'($urandom);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int g = 0; g < 3; g++) check(g);
    for (int g = 0; g < 3; g++) drive(g);
  endtask

  function automatic bit pending();
    bit p;
    p = (t_rdy != 3'b111);
    for (int g = 0; g < 3; g++)
      if (wq[g].size() > 0 || sbq[g].size() > 0)
        p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin
      cyc();
      n++;
    end
    chk("drained", 0, pending(), 1'b0);
    repeat (3) cyc();
  endtask

  task automatic push_all(input logic [3:0] w);
    for (int g = 0; g < 3; g++) wq[g].push_back(w);
  endtask

  task automatic clr_stats();
    for (int g = 0; g < 3; g++) begin
      la[g]   = 4'h0;
      dcnt[g] = 0;
      vlow[g] = 0;
      seen[g] = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [3:0] w;
    nvec = 0;
    nerr = 0;
    bb   = 1'b0;
    rst  = 1'b1;
    tin_valid = 3'b000;
    for (int g = 0; g < 3; g++) begin
      tin_data[g] = 4'h0;
      rlow[g]     = 0;
    end
    clr_stats();

    // reset held for two cycles
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    for (int g = 0; g < 3; g++)
      chk("rdy_after_rst", g, t_rdy[g], 1'b1);

    // single word 1000
    clr_stats();
    push_all(4'b1000);
    drain(40);
    chk("a_msb", 0, la[0], 4'b1000);
    chk("a_msb", 1, la[1], 4'b1000);
    chk("a_lsb", 2, la[2], 4'b0001);
    for (int g = 0; g < 3; g++)
      chk("done_cnt", g, dcnt[g], 1);

    // held valid: A then 5
    clr_stats();
    bb = 1'b1;
    push_all(4'hA);
    push_all(4'h5);
    drain(60);
    for (int g = 0; g < 3; g++)
      chk("done_cnt2", g, dcnt[g], 2);

    // back-to-back random words
    clr_stats();
    for (int i = 0; i < 4; i++) begin
      w = 4'($urandom);
      push_all(w);
    end
    drain(100);
    bb = 1'b0;
    for (int g = 0; g < 3; g++)
      chk("done_cnt4", g, dcnt[g], 4);

    // reset after two bits of F
    clr_stats();
    push_all(4'hF);
    n = 0;
    do begin
      cyc();
      n++;
    end while (sbq[0].size() != 2 && n < 20);
    chk("two_bits", 0, sbq[0].size(), 2);
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      sbq[g].delete();
      wq[g].delete();
      rlow[g] = 0;
      tin_valid[g] = 1'b0;
    end
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    for (int g = 0; g < 3; g++)
      chk("no_done", g, dcnt[g], 0);
    push_all(4'h3);
    drain(40);
    chk("a_after_rst", 0, la[0], 4'h3);
    for (int g = 0; g < 3; g++)
      chk("done_after_rst", g, dcnt[g], 1);

    // 0001 word, LSB-first shows 1,0,0,0
    clr_stats();
    push_all(4'b0001);
    drain(40);
    chk("a_lsb1", 2, la[2], 4'b1000);
    chk("a_msb1", 0, la[0], 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
